// File: rtl/effects_ctrl_scheduler_if.sv
// Control/status bundle between user-control logic and the effects scheduler.
// master: control side (drives targets and pulses); slave: scheduler.
interface effects_ctrl_scheduler_if #(
    parameter int GAIN_W = 11
);
    logic [GAIN_W-1:0] gain_target;
    logic              target_load;
    logic              gain_up;
    logic              gain_down;
    logic              sample_valid;
    logic [GAIN_W-1:0] gain_value;
    logic [GAIN_W-1:0] target_out;
    logic              ramp_busy;

    modport master (
        output gain_target, target_load, gain_up, gain_down,
        input  sample_valid, gain_value, target_out, ramp_busy
    );

    modport slave (
        input  gain_target, target_load, gain_up, gain_down,
        output sample_valid, gain_value, target_out, ramp_busy
    );
endinterface

// File: rtl/effects_ctrl_scheduler.sv
// Effects pipeline scheduler: per-sample valid strobe plus anti-zipper gain ramp.
// Gain codes are unsigned Q(GAIN_W-GAIN_FRAC).GAIN_FRAC; all math is on the raw code.
// Build option: EFFECTS_GAIN_RAMP_EN defined -> gain moves RAMP_STEP per strobe;
// undefined -> gain jumps straight to the target on the first strobe in RAMP.
module effects_ctrl_scheduler #(
    parameter int GAIN_W         = 11,
    parameter int GAIN_FRAC      = 4,
    parameter int CLK_PER_SAMPLE = 1042,
    parameter int RAMP_STEP      = 1,
    parameter int BTN_STEP       = 4,
    parameter int GAIN_MAX       = 2047,
    parameter int GAIN_RESET     = 16
) (
    input  logic clk,
    input  logic rst,
    effects_ctrl_scheduler_if.slave bus
);
    localparam int CW = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;

    typedef logic [GAIN_W:0]   wide_t;
    typedef logic [GAIN_W-1:0] gain_t;
    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_SAMPLE - 1);
    localparam wide_t         MAX_W    = wide_t'(GAIN_MAX);
    localparam wide_t         BTN_W    = wide_t'(BTN_STEP);
    localparam gain_t         G_RST    = gain_t'(GAIN_RESET);
    localparam gain_t         G_MAX    = gain_t'(GAIN_MAX);

    // Reject configurations the counter/ramp arithmetic cannot honour.
    if (CLK_PER_SAMPLE < 2 || RAMP_STEP < 1 || GAIN_FRAC > GAIN_W) begin : g_bad_cfg
        $error("effects_ctrl_scheduler: illegal parameter set");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sv_q, sv_d;
    gain_t         target_q, target_d;
    gain_t         gain_q, gain_d;
    logic          busy_q, busy_d;
    state_t        state_q, state_d;

    // Saturating arithmetic is done one bit wider so it can never wrap.
    wide_t tgt_sum, tgt_dif, load_w;
    assign tgt_sum = {1'b0, target_q} + BTN_W;
    assign tgt_dif = {1'b0, target_q} - BTN_W;
    assign load_w  = {1'b0, bus.gain_target};

    // close: this strobe lands exactly on the target and ends the ramp.
    logic close;
`ifdef EFFECTS_GAIN_RAMP_EN
    localparam gain_t STEP = gain_t'(RAMP_STEP);
    logic  go_up;
    gain_t mag;
    assign go_up = (target_q > gain_q);
    assign mag   = go_up ? (target_q - gain_q) : (gain_q - target_q);
    assign close = (mag <= STEP);
`else
    assign close = 1'b1;
`endif

    // Sample counter wraps at CLK_PER_SAMPLE; strobe registered for the last count.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        sv_d  = (cnt_d == CNT_LAST);
    end

    // Target update: load wins; simultaneous up/down cancel; clamp to [0, GAIN_MAX].
    always_comb begin
        target_d = target_q;
        if (bus.target_load) begin
            target_d = (load_w > MAX_W) ? G_MAX : bus.gain_target;
        end else if (bus.gain_up && !bus.gain_down) begin
            target_d = (tgt_sum > MAX_W) ? G_MAX : tgt_sum[GAIN_W-1:0];
        end else if (bus.gain_down && !bus.gain_up) begin
            target_d = tgt_dif[GAIN_W] ? '0 : tgt_dif[GAIN_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: enter RAMP on any mismatch, leave once gain reaches the target.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (target_q != gain_q) state_d = RAMP;
            RAMP: begin
                if (target_q == gain_q)    state_d = IDLE;
                else if (sv_q && close)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: gain only moves on a strobe while in RAMP, using the pre-edge target.
    always_comb begin
        gain_d = gain_q;
        if (state_q == RAMP && sv_q && target_q != gain_q) begin
`ifdef EFFECTS_GAIN_RAMP_EN
            if (close)      gain_d = target_q;
            else if (go_up) gain_d = gain_q + STEP;
            else            gain_d = gain_q - STEP;
`else
            gain_d = target_q;
`endif
        end
        busy_d = (state_d == RAMP);
    end

    // Datapath registers; async reset aborts any ramp in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sv_q     <= 1'b0;
            target_q <= G_RST;
            gain_q   <= G_RST;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sv_q     <= sv_d;
            target_q <= target_d;
            gain_q   <= gain_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sample_valid = sv_q;
    assign bus.gain_value   = gain_q;
    assign bus.target_out   = target_q;
    assign bus.ramp_busy    = busy_q;
endmodule

// File: tb/tb_effects_ctrl_scheduler.sv
// Self-checking bench for effects_ctrl_scheduler: directed steps plus random
// pulses, every cycle compared against a plain-integer reference model.
module tb_effects_ctrl_scheduler;
    localparam int GW   = 11;
    localparam int CPS  = 8;
    localparam int BTN  = 4;
    localparam int GMAX = 100;
`ifdef EFFECTS_GAIN_RAMP_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 1 << 20;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    effects_ctrl_scheduler_if #(.GAIN_W(GW)) bus ();

    effects_ctrl_scheduler #(
        .GAIN_W(GW), .GAIN_FRAC(4), .CLK_PER_SAMPLE(CPS), .RAMP_STEP(1),
        .BTN_STEP(BTN), .GAIN_MAX(GMAX), .GAIN_RESET(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: edges since reset, target, gain, busy flag, strobe.
    int m_n, m_tgt, m_gain;
    bit m_busy, m_sv;

    task automatic model_reset();
        m_n = 0; m_tgt = 16; m_gain = 16; m_busy = 0; m_sv = 0;
    endtask

    task automatic model_edge();
        int t_old, g_old, d, gt;
        t_old = m_tgt;
        g_old = m_gain;
        gt    = int'(bus.gain_target);
        if (bus.target_load)                  m_tgt = (gt > GMAX) ? GMAX : gt;
        else if (bus.gain_up && !bus.gain_down) m_tgt = (t_old + BTN > GMAX) ? GMAX : t_old + BTN;
        else if (bus.gain_down && !bus.gain_up) m_tgt = (t_old - BTN < 0) ? 0 : t_old - BTN;
        if (m_busy && m_sv) begin
            d = t_old - g_old;
            if (d <= STEP && d >= -STEP) m_gain = t_old;
            else if (d > 0)              m_gain = g_old + STEP;
            else                         m_gain = g_old - STEP;
        end
        m_busy = m_busy ? (m_gain != t_old) : (t_old != g_old);
        m_n++;
        m_sv = ((m_n % CPS) == CPS - 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sv"},   32'(bus.sample_valid), 32'(m_sv));
        chk({tag, ".gain"}, 32'(bus.gain_value),   32'(m_gain));
        chk({tag, ".tgt"},  32'(bus.target_out),   32'(m_tgt));
        chk({tag, ".busy"}, 32'(bus.ramp_busy),    32'(m_busy));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later, pulses cleared.
    task automatic tick(input string tag = "cyc");
        @(posedge clk);
        if (rst) model_edge();
        #1;
        chk_all(tag);
        bus.target_load = 1'b0;
        bus.gain_up     = 1'b0;
        bus.gain_down   = 1'b0;
    endtask

    task automatic load(input int v);
        bus.gain_target = GW'(v);
        bus.target_load = 1'b1;
        tick("load");
    endtask

    int gq[$];
    int exp_q[$];
    int last_g, nstrobe, r;

    initial begin
        rst = 1'b0;
        bus.gain_target = '0;
        bus.target_load = 1'b0;
        bus.gain_up     = 1'b0;
        bus.gain_down   = 1'b0;
        model_reset();

        // 1: reset state, then strobe cadence
        repeat (3) tick("rst");
        chk("rst_gain", 32'(bus.gain_value), 32'd16);
        chk("rst_tgt",  32'(bus.target_out), 32'd16);
        rst = 1'b1;
        nstrobe = 0;
        for (int i = 1; i <= 24; i++) begin
            tick("strobe");
            if (bus.sample_valid) nstrobe++;
            if (i == 7) chk("first_strobe", 32'(bus.sample_valid), 32'd1);
        end
        chk("strobe_count", 32'(nstrobe), 32'd3);

        // 2: small ramp 16 -> 20
        load(20);
        gq.delete();
        last_g = 16;
        for (int i = 0; i < 60; i++) begin
            tick("ramp20");
            if (int'(bus.gain_value) != last_g) begin
                last_g = int'(bus.gain_value);
                gq.push_back(last_g);
            end
        end
`ifdef EFFECTS_GAIN_RAMP_EN
        exp_q = '{17, 18, 19, 20};
`else
        exp_q = '{20};
`endif
        chk("ramp20_steps", 32'(gq.size()), 32'(exp_q.size()));
        foreach (exp_q[k]) if (k < gq.size()) chk("ramp20_val", 32'(gq[k]), 32'(exp_q[k]));
        chk("ramp20_busy", 32'(bus.ramp_busy), 32'd0);

        // 3: saturation at GAIN_MAX
        load(94);
        bus.gain_up = 1'b1; tick("up"); #0 tick("t3a");
        chk("up_98", 32'(bus.target_out), 32'd98);
        bus.gain_up = 1'b1; tick("up"); tick("t3b");
        chk("up_100", 32'(bus.target_out), 32'd100);
        bus.gain_up = 1'b1; tick("up"); tick("t3c");
        chk("up_sat", 32'(bus.target_out), 32'd100);
        load(200); tick("t3d");
        chk("load_sat", 32'(bus.target_out), 32'd100);

        // 4: up+down cancel; load beats up
        bus.gain_up = 1'b1; bus.gain_down = 1'b1; tick("updn"); tick("t4a");
        chk("updn_hold", 32'(bus.target_out), 32'd100);
        bus.gain_up = 1'b1; load(30); tick("t4b");
        chk("load_prio", 32'(bus.target_out), 32'd30);
        bus.gain_down = 1'b1; load(2); bus.gain_down = 1'b1; tick("dn"); tick("t4c");
        chk("down_floor", 32'(bus.target_out), 32'd0);

        // 5: reverse direction mid-ramp
        load(16);
        repeat (900) tick("settle");
        chk("settle16", 32'(bus.gain_value), 32'd16);
`ifdef EFFECTS_GAIN_RAMP_EN
        load(40);
        for (int i = 0; i < 200 && bus.gain_value != GW'(20); i++) tick("to20");
        chk("reach20", 32'(bus.gain_value), 32'd20);
        load(18);
        gq.delete();
        last_g = 20;
        for (int i = 0; i < 60; i++) begin
            tick("rev");
            if (int'(bus.gain_value) != last_g) begin
                last_g = int'(bus.gain_value);
                gq.push_back(last_g);
            end
        end
        chk("rev_steps", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("rev_19", 32'(gq[0]), 32'd19);
            chk("rev_18", 32'(gq[1]), 32'd18);
        end
        chk("rev_busy", 32'(bus.ramp_busy), 32'd0);
`endif

        // random pulses and loads against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                bus.gain_target = GW'($urandom_range(0, 150));
                bus.target_load = 1'b1;
            end else if (r == 1) bus.gain_up = 1'b1;
            else if (r == 2) bus.gain_down = 1'b1;
            else if (r == 3) begin
                bus.gain_up = 1'b1; bus.gain_down = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    bus.gain_target = GW'($urandom_range(0, 150));
                    bus.target_load = 1'b1;
                end
            end
            tick("rand");
        end

        // 6: async reset mid-ramp takes effect without a clock edge
        load(100);
        repeat (20) tick("pre_rst");
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_sv",   32'(bus.sample_valid), 32'd0);
        chk("arst_gain", 32'(bus.gain_value),   32'd16);
        chk("arst_tgt",  32'(bus.target_out),   32'd16);
        chk("arst_busy", 32'(bus.ramp_busy),    32'd0);
        repeat (2) tick("in_rst");
        rst = 1'b1;
        load(100);
        repeat (12) tick("post_rst");
`ifdef EFFECTS_GAIN_RAMP_EN
        chk("post_gain", 32'(bus.gain_value), 32'd17);
`else
        chk("post_jump", 32'(bus.gain_value), 32'd100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
